// File: rtl/barrett_seq_ctrl_2647.sv
// Sequential Barrett reducer mod 2647: one shared multiplier, valid/ready on both sides.
// Optional statistics counters (done_cnt, corr_cnt) are enabled by defining BARRETT_SEQ_STATS_EN.

module barrett_seq_chk_2647 #(
  parameter int Q     = 2647,
  parameter int DIN_W = 23
) (
  input logic             clk,
  input logic             rst,
  input logic             in_done,
  input logic [DIN_W-1:0] r
);
  localparam logic [DIN_W-1:0] Q_D = DIN_W'(Q);

  // the residue must be fully corrected whenever a result is presented
  a_r_lt_q : assert property (@(posedge clk) disable iff (rst) in_done |-> (r < Q_D));
endmodule

module barrett_seq_ctrl_2647 #(
  parameter int Q      = 2647,
  parameter int MU     = 6338,
  parameter int K      = 12,
  parameter int DIN_W  = 23,
  parameter int DOUT_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] out_data,
`ifdef BARRETT_SEQ_STATS_EN
  output logic [15:0]       done_cnt,
  output logic [15:0]       corr_cnt,
`endif
  output logic              busy
);

  localparam int P_W = 2*DIN_W - K;
  localparam logic [P_W-1:0]   MU_P = P_W'(MU);
  localparam logic [P_W-1:0]   Q_P  = P_W'(Q);
  localparam logic [DIN_W-1:0] Q_D  = DIN_W'(Q);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_MU = 3'd1,
    S_MUL_Q  = 3'd2,
    S_CORR1  = 3'd3,
    S_CORR2  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [DIN_W-1:0]    a_q, a_d;
  logic [DIN_W-1:0]    t_q, t_d;
  logic [DIN_W-1:0]    r_q, r_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DOUT_W-1:0]   out_data_q, out_data_d;
  logic                busy_q, busy_d;

  logic [P_W-1:0]      mul_a, mul_b, prod;

  // Single multiplier: (a>>K)*MU during MUL_MU, t*Q otherwise
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_q == S_MUL_MU) begin
      mul_a = P_W'(a_q >> K);
      mul_b = MU_P;
    end else begin
      mul_a = P_W'(t_q);
      mul_b = Q_P;
    end
  end

  assign prod = mul_a * mul_b;

  // Next-state and datapath updates; output registers follow the next state
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    t_d        = t_q;
    r_d        = r_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_data;
          state_d = S_MUL_MU;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_MU: begin
        t_d     = DIN_W'(prod >> K);
        state_d = S_MUL_Q;
      end
      S_MUL_Q: begin
        // t never exceeds floor(a/Q), so the difference cannot go negative
        r_d     = a_q - prod[DIN_W-1:0];
        state_d = S_CORR1;
      end
      S_CORR1: begin
        if (r_q >= Q_D) begin
          r_d = r_q - Q_D;
        end else begin
          r_d = r_q;
        end
        state_d = S_CORR2;
      end
      S_CORR2: begin
        if (r_q >= Q_D) begin
          r_d = r_q - Q_D;
        end else begin
          r_d = r_q;
        end
        out_data_d = r_d[DOUT_W-1:0];
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      t_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      t_q         <= t_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

`ifdef BARRETT_SEQ_STATS_EN
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [15:0] corr_cnt_q, corr_cnt_d;
  logic        corr_hit;

  assign corr_hit = ((state_q == S_CORR1) || (state_q == S_CORR2)) && (r_q >= Q_D);

  // Handshake and correction counters, wrapping naturally at 16 bits
  always_comb begin
    done_cnt_d = done_cnt_q;
    corr_cnt_d = corr_cnt_q;
    if (out_valid_q && out_ready) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end else begin
      done_cnt_d = done_cnt_q;
    end
    if (corr_hit) begin
      corr_cnt_d = corr_cnt_q + 16'd1;
    end else begin
      corr_cnt_d = corr_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_q <= 16'd0;
      corr_cnt_q <= 16'd0;
    end else begin
      done_cnt_q <= done_cnt_d;
      corr_cnt_q <= corr_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
  assign corr_cnt = corr_cnt_q;
`endif

  barrett_seq_chk_2647 #(.Q(Q), .DIN_W(DIN_W)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .in_done (state_q == S_DONE),
    .r       (r_q)
  );

endmodule

// File: tb/tb_barrett_seq_ctrl_2647.sv
// Bench for barrett_seq_ctrl_2647: queue-based a%Q model checked every cycle, plus directed literals.
module tb_barrett_seq_ctrl_2647;
  localparam int Q = 2647;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [22:0] in_data = 23'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_data;
  logic        busy;
`ifdef BARRETT_SEQ_STATS_EN
  logic [15:0] done_cnt;
  logic [15:0] corr_cnt;
`endif

  barrett_seq_ctrl_2647 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BARRETT_SEQ_STATS_EN
    .done_cnt  (done_cnt),
    .corr_cnt  (corr_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- model: results are a%Q, in accept order ----------------
  int          exp_q[$];
  int          acc_cnt = 0;
  int          out_cnt = 0;
  logic        stall_q = 1'b0;
  logic [11:0] held_data = 12'd0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(int'(in_data) % Q);
        acc_cnt++;
      end
      stall_q   = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  // Compare process: whenever a result is presented it must be the oldest pending a%Q
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_data_held", {20'd0, out_data}, {20'd0, held_data});
      end
      if (out_valid) begin
        chk("pending_result_exists", {31'd0, (exp_q.size() > 0)}, 32'd1);
        if (exp_q.size() > 0) chk("model_data", {20'd0, out_data}, exp_q[0]);
        chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
        chk("busy_high_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  // ---------------- stimulus helpers (called #1 after a rising edge) -----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [22:0] v);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get(input string name, input int exp);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(name, {20'd0, out_data}, exp);
    tick();
    chk({name, "_handshake"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic rnd_on = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acc0, out0;
    #1;
    do_reset();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {20'd0, out_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef BARRETT_SEQ_STATS_EN
    chk("reset_done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("reset_corr_cnt", {16'd0, corr_cnt}, 32'd0);
`endif

    // directed literals, out_ready high on the first DONE cycle
    send(23'd0);       get("lit_0", 0);
    send(23'd2646);    get("lit_2646", 2646);
    send(23'd2647);    get("lit_2647", 0);
    send(23'd5293);    get("lit_5293", 2646);
    send(23'd5294);    get("lit_2q", 0);

    // max operand: latency counted with the accept edge as edge 1, then stall in DONE
    out_ready = 1'b0;
    send(23'd8388607);
    cyc = 1;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    chk("latency_edges", cyc, 32'd5);
    chk("lit_max", {20'd0, out_data}, 32'd264);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {20'd0, out_data}, 32'd264);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;

    // reset while in MUL_Q aborts the operation
    send(23'd12345);   // now in MUL_MU
    tick();            // now in MUL_Q
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_output", {31'd0, out_valid}, 32'd0);
    end
    send(23'd100000);  get("lit_100000", 2061);

    // random stream with random back-pressure
    do_reset();
    acc0 = acc_cnt;
    out0 = out_cnt;
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(23'($urandom_range(0, 8388607)));
          if ($urandom_range(0, 3) == 0) tick();
        end
        cyc = 0;
        while ((exp_q.size() > 0) && cyc < 200) begin tick(); cyc++; end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    tick();
    chk("rand_accepts", acc_cnt - acc0, 32'd1000);
    chk("rand_outputs", out_cnt - out0, 32'd1000);
    chk("rand_drained", exp_q.size(), 32'd0);
`ifdef BARRETT_SEQ_STATS_EN
    chk("stats_done_cnt", {16'd0, done_cnt}, 32'd1000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
